// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller: holds four nibbles, walks
// them through one shared decoder with blanking dead time and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int SHOW_CYC = 50000,
    parameter int DEAD_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        load_en,
    input  logic [15:0] load_data,
    input  logic        lz_en,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        seg_en,
    output logic        frame_tick
);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam int MAX_CYC = (SHOW_CYC > DEAD_CYC) ? SHOW_CYC : DEAD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = (DEAD_CYC > 0) ? CNT_W'(DEAD_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       d_q [4];
    logic [3:0]       d_d [4];

    logic [3:0]       upper_zero;
    logic             suppressed;
    logic             lit;

    // Bulk load first, then the single-digit write overrides its slot.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            d_d[i] = d_q[i];
            if (load_en) begin
                d_d[i] = load_data[4*i +: 4];
            end
            if (wr_en && (wr_addr == 2'(i))) begin
                d_d[i] = wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_ONE;
        case (state_q)
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (DEAD_CYC > 0) begin
                        state_d = ST_BLANK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == DEAD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SHOW;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
        endcase
        frame_tick_d = (idx_q == 2'd3) && (idx_d == 2'd0);
    end

    // upper_zero[i]: digits i..3 are all zero.
    always_comb begin
        upper_zero[3] = (d_q[3] == 4'd0);
        upper_zero[2] = upper_zero[3] && (d_q[2] == 4'd0);
        upper_zero[1] = upper_zero[2] && (d_q[1] == 4'd0);
        upper_zero[0] = upper_zero[1] && (d_q[0] == 4'd0);
        suppressed    = lz_en && (idx_q != 2'd0) && upper_zero[idx_q];
        lit           = (state_q == ST_SHOW) && !suppressed;
    end

    // Reset forces the digit-0 view immediately so the pins never show stale state.
    always_comb begin
        if (reset) begin
            bcd    = 4'd0;
            seg_en = 1'b1;
            an     = 4'b1110;
        end else begin
            bcd    = d_q[idx_q];
            seg_en = lit;
            an     = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        end
        frame_tick = frame_tick_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SHOW;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                d_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_tick_q <= frame_tick_d;
            for (int i = 0; i < 4; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl; expected outputs come from a
// time-since-reset arithmetic model of the scan schedule.
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SHOW_CYC=4, DEAD_CYC=2
    logic        rst_a = 1'b1, wr_en_a = 1'b0, load_en_a = 1'b0, lz_a = 1'b0;
    logic [1:0]  wr_addr_a = 2'd0;
    logic [3:0]  wr_data_a = 4'd0;
    logic [15:0] load_data_a = 16'd0;
    logic [3:0]  bcd_a, an_a;
    logic        seg_a, ft_a;

    // Instance B: SHOW_CYC=3, DEAD_CYC=0
    logic        rst_b = 1'b1, wr_en_b = 1'b0, load_en_b = 1'b0, lz_b = 1'b0;
    logic [1:0]  wr_addr_b = 2'd0;
    logic [3:0]  wr_data_b = 4'd0;
    logic [15:0] load_data_b = 16'd0;
    logic [3:0]  bcd_b, an_b;
    logic        seg_b, ft_b;

    seg_scan_ctrl #(.SHOW_CYC(4), .DEAD_CYC(2)) dut_a (
        .clk(clk), .reset(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .load_en(load_en_a), .load_data(load_data_a),
        .lz_en(lz_a), .bcd(bcd_a), .an(an_a), .seg_en(seg_a), .frame_tick(ft_a)
    );

    seg_scan_ctrl #(.SHOW_CYC(3), .DEAD_CYC(0)) dut_b (
        .clk(clk), .reset(rst_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .load_en(load_en_b), .load_data(load_data_b),
        .lz_en(lz_b), .bcd(bcd_b), .an(an_b), .seg_en(seg_b), .frame_tick(ft_b)
    );

    int checks = 0;
    int passes = 0;

    // Model state: clocks since reset and the four digits packed d3..d0.
    int          t_a = 0, t_b = 0;
    logic [15:0] v_a = 16'd0, v_b = 16'd0;

    // Expected {frame_tick, seg_en, an, bcd} at t clocks after reset.
    function automatic logic [9:0] ref_out(input int t, input int s, input int d,
                                           input logic [15:0] v, input logic lz);
        int p, pos, di;
        logic lit, supp, seg;
        logic [3:0] nib, an;
        p    = s + d;
        pos  = t % (4 * p);
        di   = pos / p;
        lit  = (pos % p) < s;
        nib  = v[4*di +: 4];
        supp = lz && (di != 0) && ((v >> (4 * di)) == 16'h0);
        seg  = lit && !supp;
        an   = seg ? ~(4'b0001 << di) : 4'b1111;
        return {(t > 0) && (pos == 0), seg, an, nib};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_a) begin
            t_a = 0;
            v_a = 16'd0;
        end else begin
            t_a++;
            if (load_en_a) v_a = load_data_a;
            if (wr_en_a) v_a[4*wr_addr_a +: 4] = wr_data_a;
        end
        if (rst_b) begin
            t_b = 0;
            v_b = 16'd0;
        end else begin
            t_b++;
            if (load_en_b) v_b = load_data_b;
            if (wr_en_b) v_b[4*wr_addr_b +: 4] = wr_data_b;
        end
        #1;
    endtask

    task automatic idle_a();
        wr_en_a   = 1'b0;
        load_en_a = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_a = 1'b1;
        idle_a();
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {ft_a, seg_a, an_a, bcd_a};
            checks++;
            if (got !== 10'b0_1_1110_0000)
                $display("FAIL reset_state cycle %0d: got ft/seg/an/bcd=%b/%b/%b/%h required 0/1/1110/0",
                         i, got[9], got[8], got[7:4], got[3:0]);
            else passes++;
        end
        rst_a = 1'b0;
    endtask

    task automatic test_scan();
        logic [9:0] got, exp;
        int last_ft;
        int pulses;
        last_ft = -1;
        pulses  = 0;
        load_en_a   = 1'b1;
        load_data_a = 16'h4321;
        tick();
        idle_a();
        for (int i = 0; i < 60; i++) begin
            got = {ft_a, seg_a, an_a, bcd_a};
            exp = ref_out(t_a, 4, 2, v_a, lz_a);
            checks++;
            if (got !== exp)
                $display("FAIL scan t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                         t_a, got[9], got[8], got[7:4], got[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
            else passes++;
            if (ft_a === 1'b1) begin
                pulses++;
                if (last_ft >= 0) begin
                    checks++;
                    if (t_a - last_ft !== 24)
                        $display("FAIL frame_period: got %0d required 24", t_a - last_ft);
                    else passes++;
                end
                last_ft = t_a;
            end
            tick();
        end
        checks++;
        if (pulses !== 2)
            $display("FAIL frame_pulse_count: got %0d required 2", pulses);
        else passes++;
    endtask

    task automatic test_priority();
        logic [9:0] got, exp;
        load_en_a   = 1'b1;
        load_data_a = 16'hFFFF;
        wr_en_a     = 1'b1;
        wr_addr_a   = 2'd2;
        wr_data_a   = 4'd5;
        tick();
        idle_a();
        for (int i = 0; i < 24; i++) begin
            got = {ft_a, seg_a, an_a, bcd_a};
            exp = ref_out(t_a, 4, 2, v_a, lz_a);
            checks++;
            if (got !== exp)
                $display("FAIL priority t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                         t_a, got[9], got[8], got[7:4], got[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
            else passes++;
            if (an_a === 4'b1011) begin
                checks++;
                if (bcd_a !== 4'h5) $display("FAIL priority_digit2: got %h required 5", bcd_a);
                else passes++;
            end else if (an_a !== 4'b1111) begin
                checks++;
                if (bcd_a !== 4'hF) $display("FAIL priority_other: an=%b got %h required F", an_a, bcd_a);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_lz();
        logic [9:0] got, exp;
        logic [15:0] pat [2];
        pat[0] = 16'h0070;
        pat[1] = 16'h0000;
        lz_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_en_a   = 1'b1;
            load_data_a = pat[k];
            tick();
            idle_a();
            for (int i = 0; i < 24; i++) begin
                got = {ft_a, seg_a, an_a, bcd_a};
                exp = ref_out(t_a, 4, 2, v_a, lz_a);
                checks++;
                if (got !== exp)
                    $display("FAIL lz pat=%h t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                             pat[k], t_a, got[9], got[8], got[7:4], got[3:0],
                             exp[9], exp[8], exp[7:4], exp[3:0]);
                else passes++;
                if (an_a === 4'b0111) begin
                    checks++;
                    $display("FAIL lz_digit3_lit: got an=%b required 1111", an_a);
                end
                tick();
            end
        end
        lz_a = 1'b0;
    endtask

    task automatic test_reset_mid_blank();
        logic [9:0] got, exp;
        int guard;
        load_en_a   = 1'b1;
        load_data_a = 16'h4321;
        tick();
        idle_a();
        guard = 0;
        while ((t_a % 24) != 16 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40) $display("FAIL mid_blank_reach: got timeout required digit2 blank");
        else passes++;
        rst_a = 1'b1;
        #1;
        got = {ft_a, seg_a, an_a, bcd_a};
        checks++;
        if (got[8:0] !== 9'b1_1110_0000)
            $display("FAIL reset_during: got seg/an/bcd=%b/%b/%h required 1/1110/0", got[8], got[7:4], got[3:0]);
        else passes++;
        tick();
        rst_a = 1'b0;
        got = {ft_a, seg_a, an_a, bcd_a};
        checks++;
        if (got !== 10'b0_1_1110_0000)
            $display("FAIL reset_mid_blank: got ft/seg/an/bcd=%b/%b/%b/%h required 0/1/1110/0",
                     got[9], got[8], got[7:4], got[3:0]);
        else passes++;
        load_en_a   = 1'b1;
        load_data_a = 16'h4321;
        tick();
        idle_a();
        for (int i = 0; i < 30; i++) begin
            got = {ft_a, seg_a, an_a, bcd_a};
            exp = ref_out(t_a, 4, 2, v_a, lz_a);
            checks++;
            if (got !== exp)
                $display("FAIL after_reset t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                         t_a, got[9], got[8], got[7:4], got[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_write_lit();
        logic [3:0] nv;
        int guard;
        guard = 0;
        while ((t_a % 24) != 6 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40) $display("FAIL write_lit_reach: got timeout required digit1 lit");
        else passes++;
        nv = 4'($urandom_range(0, 15));
        if (nv == v_a[7:4]) nv = nv + 4'd1;
        wr_en_a   = 1'b1;
        wr_addr_a = 2'd1;
        wr_data_a = nv;
        tick();
        idle_a();
        checks++;
        if (bcd_a !== nv) $display("FAIL write_lit_bcd: got %h required %h", bcd_a, nv);
        else passes++;
        while ((t_a % 24) < 10) begin
            checks++;
            if (an_a !== 4'b1101) $display("FAIL write_lit_an t=%0d: got %b required 1101", t_a, an_a);
            else passes++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            rst_a     = ($urandom_range(0, 96) == 0);
            load_en_a = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++)
                load_data_a[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            wr_en_a   = ($urandom_range(0, 2) == 0);
            wr_addr_a = 2'($urandom_range(0, 3));
            wr_data_a = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) lz_a = ~lz_a;
            tick();
            got = {ft_a, seg_a, an_a, bcd_a};
            exp = ref_out(t_a, 4, 2, v_a, lz_a);
            if (rst_a) exp[8:0] = 9'b1_1110_0000;
            checks++;
            if (got !== exp)
                $display("FAIL random i=%0d t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                         i, t_a, got[9], got[8], got[7:4], got[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
            else passes++;
        end
        rst_a = 1'b0;
        lz_a  = 1'b0;
        idle_a();
    endtask

    task automatic test_no_dead();
        logic [9:0] got, exp;
        int last_ft;
        last_ft = -1;
        rst_b = 1'b1;
        tick();
        rst_b       = 1'b0;
        load_en_b   = 1'b1;
        load_data_b = 16'($urandom);
        tick();
        load_en_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr_en_b   = ($urandom_range(0, 4) == 0);
            wr_addr_b = 2'($urandom_range(0, 3));
            wr_data_b = 4'($urandom_range(0, 15));
            got = {ft_b, seg_b, an_b, bcd_b};
            exp = ref_out(t_b, 3, 0, v_b, lz_b);
            checks++;
            if (got !== exp)
                $display("FAIL no_dead t=%0d: got ft/seg/an/bcd=%b/%b/%b/%h required %b/%b/%b/%h",
                         t_b, got[9], got[8], got[7:4], got[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
            else passes++;
            if (an_b === 4'b1111) begin
                checks++;
                $display("FAIL no_dead_blank t=%0d: got an=1111 required a lit digit", t_b);
            end
            if (ft_b === 1'b1) begin
                if (last_ft >= 0) begin
                    checks++;
                    if (t_b - last_ft !== 12)
                        $display("FAIL no_dead_period: got %0d required 12", t_b - last_ft);
                    else passes++;
                end
                last_ft = t_b;
            end
            tick();
        end
        wr_en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_priority();
        test_lz();
        test_reset_mid_blank();
        test_write_lit();
        test_random();
        test_no_dead();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
